matrix_stream_sink: RTL and testbench

MATRIX_STREAM_SINK -- requirements
Module: matrix_stream_sink

---
 rtl/matrix_stream_sink_pkg.sv | 7 +
 rtl/matrix_buf_1w1r.sv | 28 ++
 rtl/matrix_stream_sink.sv | 75 +++++++
 tb/tb_matrix_stream_sink.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_stream_sink_pkg.sv
// matrix_stream_sink_pkg: shared FSM state and frame-length helper for matrix stream blocks
package matrix_stream_sink_pkg;
  typedef enum logic [1:0] {RECV, HOLD, DROP} state_t;
  function automatic int frame_len(input int size);
    return size * size;
  endfunction
endpackage

// File: rtl/matrix_buf_1w1r.sv
// matrix_buf_1w1r: one-write, one-registered-read element buffer; same-address read returns old data
module matrix_buf_1w1r #(
  parameter int DEPTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int AW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= re;
      if (re) rdata <= (32'(raddr) < DEPTH) ? mem[raddr] : '0;
    end
endmodule

// File: rtl/matrix_stream_sink.sv
// matrix_stream_sink: collects SIZE*SIZE-beat matrices from a stream, holds a good one until released
module matrix_stream_sink
  import matrix_stream_sink_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_tdata,
  input  logic                          s_tvalid,
  input  logic                          s_tlast,
  output logic                          s_tready,
  input  logic [$clog2(SIZE*SIZE)-1:0]  rd_addr,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          full,
  input  logic                          host_release,
  output logic                          frame_err,
  output logic [15:0]                   frame_count
);
  localparam int DEPTH = frame_len(SIZE);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_t state, state_n;
  logic [AW-1:0] wr_idx, wr_idx_n;
  logic [15:0] count_n;
  logic err_n, xfer, at_last;
  // ready depends only on registered state, never on s_tvalid
  assign s_tready = state != HOLD;
  assign full     = state == HOLD;
  assign xfer     = s_tvalid && s_tready;
  assign at_last  = wr_idx == LAST;
  always_ff @(posedge clk)
    if (rst) begin
      state       <= RECV;
      wr_idx      <= '0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      wr_idx      <= wr_idx_n;
      frame_err   <= err_n;
      frame_count <= count_n;
    end
  always_comb begin
    state_n  = state;
    wr_idx_n = wr_idx;
    err_n    = 1'b0;
    count_n  = frame_count;
    case (state)
      RECV: if (xfer) begin
        wr_idx_n = (at_last || s_tlast) ? '0 : wr_idx + 1'b1;
        err_n    = at_last != s_tlast;
        state_n  = at_last ? (s_tlast ? HOLD : DROP) : RECV;
        count_n  = (at_last && s_tlast) ? frame_count + 16'd1 : frame_count;
      end
      HOLD: state_n = host_release ? RECV : HOLD;
      DROP: state_n = (xfer && s_tlast) ? RECV : DROP;
      default: state_n = RECV;
    endcase
  end
  matrix_buf_1w1r #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .we     (xfer && state == RECV),
    .waddr  (wr_idx),
    .wdata  (s_tdata),
    .re     (rd_en),
    .raddr  (rd_addr),
    .rdata  (rd_data),
    .rvalid (rd_valid)
  );
endmodule

// File: tb/tb_matrix_stream_sink.sv
// tb_matrix_stream_sink: directed checks of framing, hold/release, readback and reset for SIZE=4
module tb_matrix_stream_sink;
  logic        clk = 0, rst = 1;
  logic [31:0] s_tdata = 0;
  logic        s_tvalid = 0, s_tlast = 0, s_tready;
  logic [3:0]  rd_addr = 0;
  logic        rd_en = 0;
  logic [31:0] rd_data;
  logic        rd_valid, full, host_release = 0, frame_err;
  logic [15:0] frame_count;
  int total = 0, bad = 0, err_cnt, err_beat;

  matrix_stream_sink #(.SIZE(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .full(full), .host_release(host_release),
    .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] base, input int n, input bit last, input bit gaps);
    err_cnt = 0;
    err_beat = 0;
    for (int i = 0; i < n; i++) begin
      int w;
      bit acc;
      w = 0;
      acc = 0;
      s_tdata = base + i;
      s_tlast = last && (i == n - 1);
      while (!acc && w < 200) begin
        s_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        acc = s_tvalid && s_tready;
        step();
        w++;
        if (acc && frame_err) begin
          err_cnt++;
          err_beat = i + 1;
        end
      end
      if (!acc) begin
        chk("beat_timeout", 0, 1);
        break;
      end
    end
    s_tvalid = 0;
    s_tlast = 0;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    rd_addr = a;
    rd_en = 1;
    step();
    rd_en = 0;
    chk(tag, rd_data, exp);
  endtask

  task automatic rel();
    host_release = 1;
    step();
    host_release = 0;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_full", full, 0);
    chk("rst_ready", s_tready, 1);
    chk("rst_count", frame_count, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_rvalid", rd_valid, 0);
    chk("rst_rdata", rd_data, 0);
    rst = 0;
    step();

    send(1, 16, 1, 0);
    chk("good_full", full, 1);
    chk("good_count", frame_count, 1);
    chk("good_ready", s_tready, 0);
    chk("good_errs", err_cnt, 0);
    rd("rd5", 5, 6);
    chk("rd5_valid", rd_valid, 1);
    step();
    chk("rvalid_drop", rd_valid, 0);
    chk("rdata_hold", rd_data, 6);
    rd("rd0", 0, 1);
    rd("rd15", 15, 16);

    s_tvalid = 1;
    s_tdata = 999;
    repeat (3) step();
    chk("bp_full", full, 1);
    chk("bp_ready", s_tready, 0);
    host_release = 1;
    step();
    host_release = 0;
    s_tvalid = 0;
    chk("rel_ready", s_tready, 1);
    chk("rel_full", full, 0);
    chk("rel_count", frame_count, 1);
    s_tvalid = 1;
    s_tdata = 101;
    rd_addr = 0;
    rd_en = 1;
    step();
    s_tvalid = 0;
    rd_en = 0;
    chk("rw_old", rd_data, 1);
    send(102, 15, 1, 0);
    chk("bp2_full", full, 1);
    chk("bp2_count", frame_count, 2);
    for (int i = 0; i < 16; i++) rd("bp2_rd", 4'(i), 101 + i);
    rel();

    send(200, 10, 1, 0);
    chk("short_errs", err_cnt, 1);
    chk("short_beat", err_beat, 10);
    chk("short_full", full, 0);
    chk("short_count", frame_count, 2);
    step();
    chk("short_err_clr", frame_err, 0);
    send(300, 16, 1, 0);
    chk("after_short_full", full, 1);
    chk("after_short_count", frame_count, 3);
    rd("after_short_rd0", 0, 300);
    rel();

    send(400, 20, 1, 0);
    chk("long_errs", err_cnt, 1);
    chk("long_beat", err_beat, 16);
    chk("long_full", full, 0);
    chk("long_count", frame_count, 3);
    chk("long_ready", s_tready, 1);
    send(500, 16, 1, 0);
    chk("after_long_full", full, 1);
    chk("after_long_count", frame_count, 4);
    rd("after_long_rd0", 0, 500);
    rd("after_long_rd15", 15, 515);
    rel();

    send(600, 7, 0, 0);
    rst = 1;
    step();
    chk("mrst_err", frame_err, 0);
    chk("mrst_full", full, 0);
    chk("mrst_count", frame_count, 0);
    rst = 0;
    step();
    chk("mrst_err2", frame_err, 0);
    send(700, 16, 1, 0);
    chk("mrst_errs", err_cnt, 0);
    chk("fresh_full", full, 1);
    chk("fresh_count", frame_count, 1);
    rd("fresh_rd0", 0, 700);
    rd("fresh_rd6", 6, 706);
    rel();

    for (int f = 0; f < 8; f++) begin
      send(1000 + 16 * f, 16, 1, 1);
      chk("rand_full", full, 1);
      chk("rand_errs", err_cnt, 0);
      for (int i = 0; i < 16; i++) rd("rand_rd", 4'(i), 1000 + 16 * f + i);
      rel();
    end
    chk("rand_count", frame_count, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
